// File: rtl/fifo_serial_tx_pkg.sv
// Shared definitions for the FIFO-fed serial transmitter: FSM encoding,
// parity mode constants and the counter-width helper.
package fifo_serial_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_PAR   = 3'd4,
        ST_STOP  = 3'd5
    } state_e;

    localparam int unsigned PAR_NONE = 32'd0;
    localparam int unsigned PAR_EVEN = 32'd1;
    localparam int unsigned PAR_ODD  = 32'd2;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int unsigned log2c(input int unsigned value);
        int unsigned w;
        w = 32'd1;
        for (int unsigned i = 32'd1; i < 32'd32; i++) begin
            if ((32'd1 << i) < value) begin
                w = i + 32'd1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_serial_tx_baud_tick.sv
// Bit-period divider: counts 0..CLK_DIV-1 and flags the last cycle of each
// serial bit. Held at zero while clr_i is high so every frame starts aligned.
module fifo_serial_tx_baud_tick
    import fifo_serial_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic clk,
    input  logic res_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned     CNT_W   = log2c(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 32'd1);

    logic [CNT_W-1:0] cnt_q;

    assign tick_o = (cnt_q == CNT_MAX);

    // Divider counter, wrapping at the end of each bit period.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (clr_i || tick_o) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from the FIFO read port and sends each as an async serial frame:
// start bit, data LSB first, optional parity bit, one stop bit.
module fifo_serial_tx
    import fifo_serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CLK_DIV = 16,
    parameter int unsigned PARITY  = 0
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic [WIDTH-1:0] fifo_rdata,
    input  logic             fifo_empty,
    output logic             fifo_shift_out,
    input  logic             enable,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned      BIT_W    = log2c(WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 32'd1);

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic             par_q;
    logic             tx_q;
    logic             tick_s;
    logic             clr_s;
    logic             start_ok_s;

    function automatic logic parity_bit(input logic [WIDTH-1:0] data);
        if (PARITY == PAR_ODD) begin
            return ~^data;
        end else begin
            return ^data;
        end
    endfunction

    fifo_serial_tx_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk    (clk),
        .res_n  (res_n),
        .clr_i  (clr_s),
        .tick_o (tick_s)
    );

    assign clr_s          = (state_q == ST_IDLE) || (state_q == ST_FETCH);
    assign start_ok_s     = enable && !fifo_empty;
    // Pop is qualified by empty so an unexpected empty in FETCH never pops.
    assign fifo_shift_out = (state_q == ST_FETCH) && !fifo_empty;
    assign busy           = (state_q != ST_IDLE);
    assign frame_done     = (state_q == ST_STOP) && tick_s;
    assign tx             = tx_q;

    // Frame sequencer; tx is only updated on bit boundaries.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= {WIDTH{1'b0}};
            bit_cnt_q <= {BIT_W{1'b0}};
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!fifo_empty) begin
                        shreg_q   <= fifo_rdata;
                        par_q     <= parity_bit(fifo_rdata);
                        bit_cnt_q <= {BIT_W{1'b0}};
                        tx_q      <= 1'b0;
                        state_q   <= ST_START;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        tx_q    <= shreg_q[0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        shreg_q <= shreg_q >> 1;
                        if (bit_cnt_q == BIT_LAST) begin
                            if (PARITY != PAR_NONE) begin
                                tx_q    <= par_q;
                                state_q <= ST_PAR;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            tx_q      <= shreg_q[1];
                        end
                    end
                end
                ST_PAR: begin
                    if (tick_s) begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        state_q <= start_ok_s ? ST_FETCH : ST_IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx with CLK_DIV=4: a no-parity instance fed
// by a small FIFO model, plus even/odd parity instances fed a fixed word.
module tb_fifo_serial_tx;

    localparam int LOGN = 256;

    logic       clk = 1'b0;
    logic       res_n = 1'b1;
    logic       enable = 1'b0;
    logic       force_empty = 1'b0;
    logic [7:0] mem [16];
    logic [7:0] rd_ptr = 8'd0;
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] fifo_rdata;
    logic       fifo_empty;
    logic       fifo_shift_out, tx, busy, frame_done;
    int         bad_pop = 0;

    logic par_en = 1'b0;
    logic par_empty = 1'b1;
    logic pe_pop, pe_tx, pe_busy, pe_done;
    logic po_pop, po_tx, po_busy, po_done;

    logic tx_log [LOGN];
    logic pop_log [LOGN];
    logic done_log [LOGN];
    logic busy_log [LOGN];
    logic pe_tx_log [LOGN];
    logic po_tx_log [LOGN];
    logic pe_done_log [LOGN];
    logic po_done_log [LOGN];
    logic pe_pop_log [LOGN];
    logic po_pop_log [LOGN];
    int   lc;

    int n_vec = 0;
    int n_err = 0;

    assign fifo_rdata = mem[rd_ptr[3:0]];
    assign fifo_empty = (rd_ptr == wr_ptr) || force_empty;

    fifo_serial_tx #(.WIDTH(8), .CLK_DIV(4), .PARITY(0)) u_dut (
        .clk(clk), .res_n(res_n), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
        .fifo_shift_out(fifo_shift_out), .enable(enable), .tx(tx), .busy(busy),
        .frame_done(frame_done)
    );

    fifo_serial_tx #(.WIDTH(8), .CLK_DIV(4), .PARITY(1)) u_dut_even (
        .clk(clk), .res_n(res_n), .fifo_rdata(8'h07), .fifo_empty(par_empty),
        .fifo_shift_out(pe_pop), .enable(par_en), .tx(pe_tx), .busy(pe_busy),
        .frame_done(pe_done)
    );

    fifo_serial_tx #(.WIDTH(8), .CLK_DIV(4), .PARITY(2)) u_dut_odd (
        .clk(clk), .res_n(res_n), .fifo_rdata(8'h07), .fifo_empty(par_empty),
        .fifo_shift_out(po_pop), .enable(par_en), .tx(po_tx), .busy(po_busy),
        .frame_done(po_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_shift_out) begin
            rd_ptr <= rd_ptr + 8'd1;
            if (fifo_empty) begin
                bad_pop <= bad_pop + 1;
            end
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[3:0]] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (lc < LOGN) begin
                tx_log[lc]      = tx;
                pop_log[lc]     = fifo_shift_out;
                done_log[lc]    = frame_done;
                busy_log[lc]    = busy;
                pe_tx_log[lc]   = pe_tx;
                po_tx_log[lc]   = po_tx;
                pe_done_log[lc] = pe_done;
                po_done_log[lc] = po_done;
                pe_pop_log[lc]  = pe_pop;
                po_pop_log[lc]  = po_pop;
                lc++;
            end
        end
    endtask

    function automatic logic tx_at(input int idx);
        if (idx >= 0 && idx < LOGN) return tx_log[idx];
        return 1'b0;
    endfunction

    // Samples the middle cycle of each data bit of a frame whose pop was at p.
    function automatic logic [7:0] decode(input int p);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            d[i] = tx_at(p + 6 + 4 * i);
        end
        return d;
    endfunction

    function automatic int count_ones(input int which, input int n);
        int c = 0;
        for (int i = 0; i < n && i < LOGN; i++) begin
            case (which)
                0: c += int'(pop_log[i]);
                1: c += int'(done_log[i]);
                2: c += int'(!tx_log[i]);
                3: c += int'(pe_pop_log[i]);
                4: c += int'(pe_done_log[i]);
                5: c += int'(po_done_log[i]);
                default: c += int'(po_pop_log[i]);
            endcase
        end
        return c;
    endfunction

    initial begin
        logic [9:0] a5_frame;
        int p1, p2, np;
        a5_frame = 10'b1101001010;
        p1 = 0;
        p2 = 0;
        lc = 0;

        // Reset held with data available and enable high.
        #1 res_n = 1'b0;
        enable = 1'b1;
        push(8'hA5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_vec("rst_tx", tx, 1);
            check_vec("rst_busy", busy, 0);
            check_vec("rst_pop", fifo_shift_out, 0);
        end
        res_n = 1'b1;

        // Single 0xA5 frame straight out of reset.
        lc = 0;
        run_cycles(45);
        check_vec("lat_pop", pop_log[0], 1);
        check_vec("lat_tx", tx_log[1], 0);
        for (int c = 1; c <= 40; c++) begin
            check_vec("a5_tx", tx_log[c], a5_frame[(c - 1) / 4]);
        end
        check_vec("a5_pops", count_ones(0, 45), 1);
        check_vec("a5_done_cnt", count_ones(1, 45), 1);
        check_vec("a5_done_at40", done_log[40], 1);
        check_vec("a5_busy_after", busy_log[41], 0);
        check_vec("a5_tx_idle", tx_log[44], 1);

        // Two queued words sent back to back.
        push(8'h01);
        push(8'hFF);
        lc = 0;
        run_cycles(90);
        np = 0;
        for (int i = 0; i < 90; i++) begin
            if (pop_log[i]) begin
                if (np == 0) p1 = i;
                else if (np == 1) p2 = i;
                np++;
            end
        end
        check_vec("b2b_pops", np, 2);
        check_vec("b2b_first_pop", p1, 0);
        check_vec("b2b_gap", p2 - p1, 41);
        check_vec("b2b_word0", decode(p1), 8'h01);
        check_vec("b2b_word1", decode(p2), 8'hFF);
        check_vec("b2b_stop", tx_at(p2 - 1), 1);
        check_vec("b2b_fetch", tx_at(p2), 1);
        check_vec("b2b_start", tx_at(p2 + 1), 0);
        check_vec("b2b_done_cnt", count_ones(1, 90), 2);

        // Even and odd parity on 0x07.
        par_en = 1'b1;
        par_empty = 1'b0;
        lc = 0;
        run_cycles(2);
        par_empty = 1'b1;
        par_en = 1'b0;
        run_cycles(50);
        check_vec("par_pop0", pe_pop_log[0], 1);
        check_vec("par_pops_even", count_ones(3, 52), 1);
        check_vec("par_pops_odd", count_ones(6, 52), 1);
        check_vec("par_start", pe_tx_log[1], 0);
        check_vec("par_bit0", pe_tx_log[6], 1);
        check_vec("par_bit3", pe_tx_log[18], 0);
        check_vec("par_even_bit", pe_tx_log[38], 1);
        check_vec("par_odd_bit", po_tx_log[38], 0);
        check_vec("par_stop", pe_tx_log[42], 1);
        check_vec("par_no_done40", pe_done_log[40], 0);
        check_vec("par_even_done44", pe_done_log[44], 1);
        check_vec("par_odd_done44", po_done_log[44], 1);
        check_vec("par_even_done_cnt", count_ones(4, 52), 1);
        check_vec("par_odd_done_cnt", count_ones(5, 52), 1);

        // Enable dropped during the data bits of the first of three words.
        push(8'h11);
        push(8'h22);
        push(8'h33);
        lc = 0;
        run_cycles(10);
        enable = 1'b0;
        run_cycles(60);
        check_vec("en_pops", count_ones(0, 70), 1);
        check_vec("en_word", decode(0), 8'h11);
        check_vec("en_done40", done_log[40], 1);
        check_vec("en_done_cnt", count_ones(1, 70), 1);
        check_vec("en_idle", busy_log[69], 0);
        check_vec("en_not_empty", fifo_empty, 0);
        enable = 1'b1;
        run_cycles(1);
        check_vec("en_repop", pop_log[70], 1);

        // Asynchronous reset in the middle of data bit 3 of 0x22.
        run_cycles(18);
        check_vec("ar_mid_tx", tx, 0);
        #2 res_n = 1'b0;
        force_empty = 1'b1;
        #1;
        check_vec("ar_tx", tx, 1);
        check_vec("ar_busy", busy, 0);
        check_vec("ar_done", frame_done, 0);
        check_vec("ar_pop", fifo_shift_out, 0);
        @(negedge clk);
        @(negedge clk);
        res_n = 1'b1;
        lc = 0;
        run_cycles(12);
        check_vec("ar_pops_after", count_ones(0, 12), 0);
        check_vec("ar_tx_low_after", count_ones(2, 12), 0);
        check_vec("ar_done_after", count_ones(1, 12), 0);
        check_vec("ar_busy_after", busy_log[11], 0);

        check_vec("pop_while_empty", bad_pop, 0);
        check_vec("par_even_idle", pe_busy, 0);
        check_vec("par_odd_idle", po_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
